// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus responder: command-address layout,
// FSM state encoding, CR0 reset value and wrapped-burst group decode.
package hyperbus_pkg;

   typedef struct packed {
      logic        rw;
      logic        as;
      logic        burst;
      logic [28:0] row;
      logic [12:0] rsvd;
      logic [2:0]  col;
   } ca_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CA,
      ST_LAT,
      ST_XFER,
      ST_REG_WR,
      ST_DONE
   } resp_state_e;

   localparam logic [15:0] CR0_RST  = 16'h8F1F;
   localparam logic [31:0] CR0_ADDR = 32'h0000_0800;

   // Returns (group words - 1) so it can be used directly as the in-group offset mask.
   function automatic logic [31:0] wrap_words(input logic [1:0] burst_len);
      case (burst_len)
         2'b00:   return 32'd63;
         2'b01:   return 32'd31;
         2'b10:   return 32'd7;
         default: return 32'd15;
      endcase
   endfunction

endpackage

// File: rtl/hyperbus_responder_if.sv
// Word-level HyperBus link as seen behind the DDR PHY: controller drives CS/DQ/mask,
// the responder drives read data and RWDS.
interface hyperbus_responder_if;
   logic        hyper_cs_ni;
   logic [15:0] dq_i;
   logic [1:0]  rwds_i;
   logic [15:0] dq_o;
   logic        dq_oe_o;
   logic [1:0]  rwds_o;
   logic        rwds_oe_o;

   modport master (
      output hyper_cs_ni, dq_i, rwds_i,
      input  dq_o, dq_oe_o, rwds_o, rwds_oe_o
   );

   modport slave (
      input  hyper_cs_ni, dq_i, rwds_i,
      output dq_o, dq_oe_o, rwds_o, rwds_oe_o
   );
endinterface

// File: rtl/hyperbus_resp_mem.sv
// Single-port 16-bit backing RAM with per-byte write enables and registered read.
// Contents are deliberately not reset.
module hyperbus_resp_mem #(
   parameter int WORDS = 1024
) (
   input  logic                     clk_i,
   input  logic                     en,
   input  logic                     we,
   input  logic [1:0]               be,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [15:0]              wdata,
   output logic [15:0]              rdata
);

   logic [15:0] mem [WORDS];

   always_ff @(posedge clk_i) begin
      if (en) begin
         if (we) begin
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/hyperbus_responder.sv
// HyperRAM-style responder: decodes the 3-word command-address, applies initial latency
// and serves linear/wrapped bursts from the internal RAM or the ID0/CR0 register space.
//
// state     | meaning
// ST_IDLE   | bus idle; c0 captured when CS goes low
// ST_CA     | receiving c1, then c2 (decode)
// ST_LAT    | initial latency countdown; first read issued on terminal count
// ST_XFER   | one data word per cycle (read or masked write)
// ST_REG_WR | zero-latency register write word
// ST_DONE   | register write done, wait for CS high
module hyperbus_responder
   import hyperbus_pkg::*;
#(
   parameter int          MEM_WORDS  = 1024,
   parameter int          LAT_CYCLES = 6,
   parameter int          FIXED_2X   = 1,
   parameter logic [15:0] ID0_VAL    = 16'h0C81
) (
   input  logic              clk_i,
   input  logic              rst_i,
   hyperbus_responder_if.slave bus
);

   localparam int         AW        = $clog2(MEM_WORDS);
   localparam int         LAT_TOTAL = LAT_CYCLES * ((FIXED_2X != 0) ? 2 : 1);
   localparam logic [7:0] LAT_LOAD  = 8'(LAT_TOTAL - 2);
   localparam logic [1:0] CA_RWDS   = (FIXED_2X != 0) ? 2'b11 : 2'b00;

   resp_state_e state, state_nxt;

   logic [31:0] ca_hi;
   logic        ca_second;
   logic        rd_q, reg_q, lin_q;
   logic [31:0] addr_q;
   logic [7:0]  lat_cnt;
   logic [15:0] cr0_q;
   logic [15:0] reg_rd_q;

   ca_t         ca_w;
   logic [31:0] ca_addr;
   logic        cs_act;
   logic        ca_phase, issue_rd, rd_beat, wr_beat, cr0_wr;
   logic [31:0] wrap_m, addr_nxt;
   logic [15:0] reg_val, mem_rdata;
   logic        mem_en;
   logic        unused_ca;

   assign cs_act    = ~bus.hyper_cs_ni;
   assign ca_w      = ca_t'({ca_hi, bus.dq_i});
   assign ca_addr   = {ca_w.row, ca_w.col};
   assign unused_ca = ^ca_w.rsvd;

   // Wrapped bursts keep the aligned group bits and roll only the low offset bits.
   assign wrap_m   = wrap_words(cr0_q[1:0]);
   assign addr_nxt = lin_q ? addr_q + 32'd1
                           : (addr_q & ~wrap_m) | ((addr_q + 32'd1) & wrap_m);

   always_comb begin
      reg_val = '0;
      if (addr_q == 32'h0)          reg_val = ID0_VAL;
      else if (addr_q == CR0_ADDR)  reg_val = cr0_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ca_phase  = 1'b0;
      issue_rd  = 1'b0;
      rd_beat   = 1'b0;
      wr_beat   = 1'b0;
      cr0_wr    = 1'b0;
      case (state)
         ST_IDLE: begin
            ca_phase = cs_act;
            if (cs_act) state_nxt = ST_CA;
         end
         ST_CA: begin
            ca_phase = cs_act;
            if (!cs_act)        state_nxt = ST_IDLE;
            else if (ca_second) state_nxt = (!ca_w.rw && ca_w.as) ? ST_REG_WR : ST_LAT;
         end
         ST_LAT: begin
            if (!cs_act) state_nxt = ST_IDLE;
            else if (lat_cnt == 8'd0) begin
               issue_rd  = rd_q;
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (!cs_act) state_nxt = ST_IDLE;
            else begin
               rd_beat  = rd_q;
               issue_rd = rd_q;
               wr_beat  = ~rd_q;
            end
         end
         ST_REG_WR: begin
            if (!cs_act) state_nxt = ST_IDLE;
            else begin
               cr0_wr    = addr_q[11];
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!cs_act) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ca_hi     <= '0;
         ca_second <= 1'b0;
         rd_q      <= 1'b0;
         reg_q     <= 1'b0;
         lin_q     <= 1'b0;
         addr_q    <= '0;
         lat_cnt   <= '0;
         cr0_q     <= CR0_RST;
         reg_rd_q  <= '0;
      end else begin
         if (state == ST_IDLE && cs_act) begin
            ca_hi[31:16] <= bus.dq_i;
            ca_second    <= 1'b0;
         end
         if (state == ST_CA && cs_act) begin
            if (!ca_second) begin
               ca_hi[15:0] <= bus.dq_i;
               ca_second   <= 1'b1;
            end else begin
               rd_q    <= ca_w.rw;
               reg_q   <= ca_w.as;
               lin_q   <= ca_w.burst;
               addr_q  <= ca_addr;
               lat_cnt <= LAT_LOAD;
            end
         end
         if (state == ST_LAT && lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
         if (issue_rd) begin
            reg_rd_q <= reg_val;
            addr_q   <= addr_nxt;
         end
         if (wr_beat) addr_q <= addr_nxt;
         if (cr0_wr)  cr0_q  <= bus.dq_i;
      end
   end

   assign mem_en = (issue_rd & ~reg_q) | wr_beat;

   hyperbus_resp_mem #(.WORDS(MEM_WORDS)) u_mem (
      .clk_i (clk_i),
      .en    (mem_en),
      .we    (wr_beat),
      .be    (~bus.rwds_i),
      .addr  (addr_q[AW-1:0]),
      .wdata (bus.dq_i),
      .rdata (mem_rdata)
   );

   // Enables drop combinationally on CS high or reset so the PHY releases the bus at once.
   assign bus.dq_oe_o   = rd_beat & ~rst_i;
   assign bus.dq_o      = (rd_beat & ~rst_i) ? (reg_q ? reg_rd_q : mem_rdata) : 16'h0000;
   assign bus.rwds_oe_o = (ca_phase | rd_beat) & ~rst_i;
   assign bus.rwds_o    = rst_i    ? 2'b00   :
                          ca_phase ? CA_RWDS :
                          rd_beat  ? 2'b10   : 2'b00;

endmodule

// File: tb/tb_hyperbus_responder.sv
// Cycle-level bench for hyperbus_responder: directed transactions plus randomized
// write/read-back bursts compared against an array model of memory and CR0.
module tb_hyperbus_responder;

   localparam int          MW  = 1024;
   localparam int          LAT = 12;
   localparam logic [15:0] ID0 = 16'h0C81;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] m_mem   [MW];
   bit          m_valid [MW];
   logic [15:0] m_cr0;
   logic [15:0] wbuf [16];
   logic [1:0]  mbuf [16];

   logic [31:0] a;
   int          n;
   bit          lin, lin2;
   logic [47:0] ca_tmp;

   hyperbus_responder_if bus ();

   hyperbus_responder #(
      .MEM_WORDS (MW),
      .LAT_CYCLES(6),
      .FIXED_2X  (1),
      .ID0_VAL   (ID0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One link cycle: drive inputs at the falling edge, outputs are sampled 1 ns later.
   task automatic cyc(input logic cs_n, input logic [15:0] dq, input logic [1:0] msk);
      @(negedge clk);
      bus.hyper_cs_ni = cs_n;
      bus.dq_i        = dq;
      bus.rwds_i      = msk;
      #1;
   endtask

   function automatic logic [31:0] burst_addr(input bit lin_b, input logic [31:0] start, input int k);
      logic [31:0] g, base;
      if (lin_b) return start + 32'(k);
      case (m_cr0[1:0])
         2'b00:   g = 32'd64;
         2'b01:   g = 32'd32;
         2'b10:   g = 32'd8;
         default: g = 32'd16;
      endcase
      base = start - (start % g);
      return base + ((start - base + 32'(k)) % g);
   endfunction

   function automatic logic [15:0] reg_model(input logic [31:0] ra);
      if (ra == 32'h0)   return ID0;
      if (ra == 32'h800) return m_cr0;
      return 16'h0000;
   endfunction

   task automatic send_ca(input bit rd, input bit sp, input bit lb, input logic [31:0] sa);
      logic [47:0] ca;
      logic [15:0] w;
      ca = {rd, sp, lb, sa[31:3], 13'h0, sa[2:0]};
      for (int i = 0; i < 3; i++) begin
         w = ca[47-16*i -: 16];
         cyc(1'b0, w, 2'b00);
         chk("ca_rwds_oe", 32'(bus.rwds_oe_o), 32'd1);
         chk("ca_rwds",    32'(bus.rwds_o),    32'd3);
         chk("ca_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      end
   endtask

   task automatic data_phase(input bit rd, input bit sp, input bit lb, input logic [31:0] sa, input int cnt);
      logic [31:0] ak;
      int          idx;
      for (int i = 1; i < LAT; i++) begin
         cyc(1'b0, 16'h0, 2'b00);
         chk("lat_dq_oe", 32'(bus.dq_oe_o), 32'd0);
      end
      for (int k = 0; k < cnt; k++) begin
         ak  = burst_addr(lb, sa, k);
         idx = int'(ak % 32'(MW));
         cyc(1'b0, wbuf[k], mbuf[k]);
         if (rd) begin
            chk("rd_dq_oe",   32'(bus.dq_oe_o),   32'd1);
            chk("rd_rwds",    32'(bus.rwds_o),    32'd2);
            chk("rd_rwds_oe", 32'(bus.rwds_oe_o), 32'd1);
            if (sp)                chk("reg_rd", 32'(bus.dq_o), 32'(reg_model(ak)));
            else if (m_valid[idx]) chk("mem_rd", 32'(bus.dq_o), 32'(m_mem[idx]));
         end else begin
            chk("wr_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
            if (!mbuf[k][1]) m_mem[idx][15:8] = wbuf[k][15:8];
            if (!mbuf[k][0]) m_mem[idx][7:0]  = wbuf[k][7:0];
            if (mbuf[k] == 2'b00) m_valid[idx] = 1'b1;
         end
      end
   endtask

   task automatic end_xfer();
      cyc(1'b1, 16'h0, 2'b00);
      chk("end_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      chk("end_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
   endtask

   task automatic xact(input bit rd, input bit sp, input bit lb, input logic [31:0] sa, input int cnt);
      send_ca(rd, sp, lb, sa);
      if (!rd && sp) begin
         cyc(1'b0, wbuf[0], 2'b00);
         chk("regwr_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
         if (sa[11]) m_cr0 = wbuf[0];
      end else begin
         data_phase(rd, sp, lb, sa, cnt);
      end
      end_xfer();
   endtask

   task automatic clear_masks();
      for (int i = 0; i < 16; i++) mbuf[i] = 2'b00;
   endtask

   initial begin
      rst             = 1'b1;
      bus.hyper_cs_ni = 1'b1;
      bus.dq_i        = 16'h0;
      bus.rwds_i      = 2'b00;
      m_cr0           = 16'h8F1F;
      for (int i = 0; i < MW; i++) m_valid[i] = 1'b0;
      clear_masks();

      cyc(1'b1, 16'h0, 2'b00);
      cyc(1'b0, 16'hFFFF, 2'b00);
      chk("rst_dq",      32'(bus.dq_o),      32'd0);
      chk("rst_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      chk("rst_rwds",    32'(bus.rwds_o),    32'd0);
      chk("rst_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
      @(negedge clk);
      rst             = 1'b0;
      bus.hyper_cs_ni = 1'b1;
      cyc(1'b1, 16'h0, 2'b00);
      chk("idle_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      chk("idle_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);

      // linear write/read at 0x10
      for (int i = 0; i < 4; i++) wbuf[i] = 16'(16'h1111 * (i + 1));
      xact(1'b0, 1'b0, 1'b1, 32'h10, 4);
      xact(1'b1, 1'b0, 1'b1, 32'h10, 4);

      // byte-masked write over 0x5555
      wbuf[0] = 16'h5555;
      xact(1'b0, 1'b0, 1'b1, 32'h20, 1);
      wbuf[0] = 16'hABCD; mbuf[0] = 2'b10;
      xact(1'b0, 1'b0, 1'b1, 32'h20, 1);
      clear_masks();
      xact(1'b1, 1'b0, 1'b1, 32'h20, 1);

      // wrapped reads: reset CR0 (16-word group), then 8-word group after CR0 write
      for (int i = 0; i < 16; i++) wbuf[i] = 16'(16'h2000 + i);
      xact(1'b0, 1'b0, 1'b1, 32'h20, 16);
      xact(1'b1, 1'b0, 1'b0, 32'h2E, 4);
      wbuf[0] = 16'h8F1E;
      xact(1'b0, 1'b1, 1'b0, 32'h800, 1);
      xact(1'b1, 1'b1, 1'b1, 32'h800, 1);
      xact(1'b1, 1'b0, 1'b0, 32'h2E, 4);

      // ID0 and a reserved register address
      xact(1'b1, 1'b1, 1'b1, 32'h0, 1);
      xact(1'b1, 1'b1, 1'b1, 32'h1, 1);

      // CA aborted after c1: register write and memory write must leave no trace
      ca_tmp = {1'b0, 1'b1, 1'b0, 29'h100, 13'h0, 3'h0};
      cyc(1'b0, ca_tmp[47:32], 2'b00);
      cyc(1'b0, ca_tmp[31:16], 2'b00);
      chk("abort_c1_rwds_oe", 32'(bus.rwds_oe_o), 32'd1);
      cyc(1'b1, 16'h0000, 2'b00);
      chk("abort_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
      chk("abort_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      cyc(1'b1, 16'h0000, 2'b00);
      xact(1'b1, 1'b1, 1'b1, 32'h800, 1);
      ca_tmp = {1'b0, 1'b0, 1'b1, 29'h2, 13'h0, 3'h0};
      cyc(1'b0, ca_tmp[47:32], 2'b00);
      cyc(1'b0, ca_tmp[31:16], 2'b00);
      cyc(1'b1, 16'hDEAD, 2'b00);
      chk("abort_wr_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
      for (int i = 0; i < 14; i++) cyc(1'b1, 16'hDEAD, 2'b00);
      xact(1'b1, 1'b0, 1'b1, 32'h10, 1);

      // reset in the middle of a read burst
      send_ca(1'b1, 1'b0, 1'b1, 32'h10);
      data_phase(1'b1, 1'b0, 1'b1, 32'h10, 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_dq_oe",   32'(bus.dq_oe_o),   32'd0);
      chk("midrst_rwds_oe", 32'(bus.rwds_oe_o), 32'd0);
      chk("midrst_dq",      32'(bus.dq_o),      32'd0);
      chk("midrst_rwds",    32'(bus.rwds_o),    32'd0);
      @(negedge clk);
      rst             = 1'b0;
      bus.hyper_cs_ni = 1'b1;
      m_cr0           = 16'h8F1F;
      for (int i = 0; i < MW; i++) m_valid[i] = 1'b0;
      cyc(1'b1, 16'h0, 2'b00);
      xact(1'b1, 1'b1, 1'b1, 32'h800, 1);
      for (int i = 0; i < 4; i++) wbuf[i] = 16'(16'h3A00 + i);
      xact(1'b0, 1'b0, 1'b1, 32'h300, 4);
      xact(1'b1, 1'b0, 1'b1, 32'h300, 4);

      // randomized bursts, occasionally changing the wrap group size
      for (int t = 0; t < 20; t++) begin
         if (t % 5 == 4) begin
            wbuf[0] = {14'h23C7, 2'($urandom())};
            mbuf[0] = 2'b00;
            xact(1'b0, 1'b1, 1'b0, 32'h800, 1);
         end
         a   = $urandom();
         n   = int'($urandom_range(1, 8));
         lin = 1'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            wbuf[k] = 16'($urandom());
            mbuf[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
         end
         xact(1'b0, 1'b0, lin, a, n);
         clear_masks();
         lin2 = 1'($urandom_range(0, 1));
         xact(1'b1, 1'b0, lin2, a, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
